// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pkg
//  Brief    : Shared widths and legal prescale values for the UART RX sampler.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int c_PRESCALE_W = 6;
    localparam int c_BIT_CNT_W  = 4;

    localparam int c_PRESCALE_8  = 8;
    localparam int c_PRESCALE_16 = 16;
    localparam int c_PRESCALE_32 = 32;

    function automatic logic is_legal_prescale(input logic [31:0] p);
        return (p == 32'(c_PRESCALE_8)) || (p == 32'(c_PRESCALE_16)) ||
               (p == 32'(c_PRESCALE_32));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler_edge_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : edge_bit_counter
//  Brief    : Oversample tick and bit counters for one UART frame.
//  Revision : 1.0 - initial release
// ============================================================================
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = c_PRESCALE_W,
    parameter int BIT_CNT_W  = c_BIT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_bits,
    output logic                  active,
    output logic [PRESCALE_W-1:0] prescale_q,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_done
);

    logic                  r_enable_d;
    logic                  r_run;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;

    logic                  w_rise;
    logic                  w_run;
    logic [PRESCALE_W-1:0] w_prescale_legal;
    logic [PRESCALE_W-1:0] w_prescale;
    logic                  w_edge_last;
    logic                  w_bit_last;

    // r_enable_d resets high so an enable held through reset is not a new frame.
    assign w_rise           = enable & ~r_enable_d;
    assign w_run            = enable & (r_run | w_rise);
    assign w_prescale_legal = is_legal_prescale(32'(prescale)) ? prescale
                                                               : PRESCALE_W'(c_PRESCALE_8);
    assign w_prescale       = w_rise ? w_prescale_legal : r_prescale;
    assign w_edge_last      = (r_edge_cnt == (w_prescale - PRESCALE_W'(1)));
    assign w_bit_last       = (r_bit_cnt == (frame_bits - BIT_CNT_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enable_d <= 1'b1;
            r_run      <= 1'b0;
            r_prescale <= PRESCALE_W'(c_PRESCALE_8);
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_enable_d <= enable;
            r_run      <= w_run;
            if (w_rise) begin
                r_prescale <= w_prescale_legal;
            end
            if (!w_run) begin
                r_edge_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if (w_edge_last) begin
                r_edge_cnt <= '0;
                r_bit_cnt  <= w_bit_last ? '0 : (r_bit_cnt + BIT_CNT_W'(1));
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
            end
        end
    end

    assign active     = w_run;
    assign prescale_q = w_prescale;
    assign edge_cnt   = r_edge_cnt;
    assign bit_cnt    = r_bit_cnt;
    assign bit_done   = w_run & w_edge_last & w_bit_last;

endmodule
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sampler
//  Brief    : RX line synchroniser, 3-tap majority voter and frame counters.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = c_PRESCALE_W,
    parameter int BIT_CNT_W  = c_BIT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  enable,
    input  logic                  data_sample_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_bits,
    output logic                  rx_sync,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_done
);

    logic                  r_sync_meta;
    logic                  r_sync;
    logic                  r_s0;
    logic                  r_s1;
    logic                  r_sampled_bit;
    logic                  r_sample_valid;

    logic                  w_active;
    logic [PRESCALE_W-1:0] w_prescale;
    logic [PRESCALE_W-1:0] w_half;
    logic                  w_sampling;
    logic                  w_tick_s0;
    logic                  w_tick_s1;
    logic                  w_tick_vote;
    logic                  w_vote;

    edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_edge_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .prescale   (prescale),
        .frame_bits (frame_bits),
        .active     (w_active),
        .prescale_q (w_prescale),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .bit_done   (bit_done)
    );

    // Three taps straddle the bit centre: P/2-2, P/2-1 and the live value at P/2.
    assign w_half      = w_prescale >> 1;
    assign w_sampling  = w_active & data_sample_en;
    assign w_tick_s0   = w_sampling & (edge_cnt == (w_half - PRESCALE_W'(2)));
    assign w_tick_s1   = w_sampling & (edge_cnt == (w_half - PRESCALE_W'(1)));
    assign w_tick_vote = w_sampling & (edge_cnt == w_half);
    assign w_vote      = (r_s0 & r_s1) | (r_s0 & r_sync) | (r_s1 & r_sync);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_meta    <= 1'b1;
            r_sync         <= 1'b1;
            r_s0           <= 1'b1;
            r_s1           <= 1'b1;
            r_sampled_bit  <= 1'b1;
            r_sample_valid <= 1'b0;
        end else begin
            r_sync_meta    <= rx_in;
            r_sync         <= r_sync_meta;
            r_sample_valid <= w_tick_vote;
            if (w_tick_s0) begin
                r_s0 <= r_sync;
            end
            if (w_tick_s1) begin
                r_s1 <= r_sync;
            end
            if (w_tick_vote) begin
                r_sampled_bit <= w_vote;
            end
        end
    end

    assign rx_sync      = r_sync;
    assign sampled_bit  = r_sampled_bit;
    assign sample_valid = r_sample_valid;

endmodule
`default_nettype wire

// File: doc/uart_rx_sampler.md
UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 Parameter: PRESCALE_W, 6, width of prescale and edge counter.
REQ-002 Parameter: BIT_CNT_W, 4, width of bit counter and frame_bits.
REQ-003 Port: clk  input  1  clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: rx_in  input  1  raw serial line, asynchronous to clk, idle high.
REQ-006 Port: enable  input  1  from RX FSM; high = frame in progress, counters run.
REQ-007 Port: data_sample_en  input  1  from RX FSM; high = majority sampling active.
REQ-008 Port: prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
REQ-009 Port: frame_bits  input  BIT_CNT_W  bits per frame including start/stop, legal range 2..15.
REQ-010 Port: rx_sync  output  1  synchronised rx_in, used by FSM for start-edge detection.
REQ-011 Port: sampled_bit  output  1  majority-voted bit value; feeds start/parity/stop checkers.
REQ-012 Port: sample_valid  output  1  one-cycle pulse when sampled_bit is updated.
REQ-013 Port: edge_cnt  output  PRESCALE_W  oversample tick index within current bit.
REQ-014 Port: bit_cnt  output  BIT_CNT_W  bit index within current frame.
REQ-015 Port: bit_done  output  1  one-cycle pulse on last tick of last frame bit.

Function
REQ-016 rx_in SHALL pass through a 2-flop synchroniser; rx_sync lags rx_in by 2 cycles.
REQ-017 On enable rising (enable=1, previous-cycle enable=0), prescale SHALL be latched; values other than 8/16/32 SHALL be latched as 8; prescale changes mid-frame SHALL be ignored.
REQ-018 While enable=1, edge_cnt SHALL increment each cycle from 0 to P-1 (P = latched prescale), then wrap to 0.
REQ-019 On edge_cnt wrap, bit_cnt SHALL increment; when bit_cnt=frame_bits-1 and edge_cnt=P-1, bit_cnt SHALL wrap to 0 and bit_done SHALL pulse high that same cycle (combinational decode of current counts, registered next cycle is NOT allowed).
REQ-020 When enable=0, edge_cnt and bit_cnt SHALL be 0 on the next clock edge; enable deassert mid-frame aborts with no bit_done.
REQ-021 While data_sample_en=1: rx_sync SHALL be captured into s0 at edge_cnt=P/2-2 and into s1 at edge_cnt=P/2-1.
REQ-022 At edge_cnt=P/2 with data_sample_en=1, sampled_bit SHALL load maj(s0, s1, rx_sync) on that clock edge and sample_valid SHALL be high for the following single cycle.
REQ-023 sampled_bit SHALL hold its value between updates, including when enable or data_sample_en is low.
REQ-024 If data_sample_en deasserts between s0 capture and edge_cnt=P/2, no update and no sample_valid SHALL occur for that bit.
REQ-025 Latency: rx_in change to affecting the vote = 2 cycles; vote point to sample_valid = 1 cycle.
REQ-026 Counter widths SHALL be sufficient for P=32 (edge_cnt max 31); no overflow path exists for legal inputs.

Reset
REQ-027 On rst=0: edge_cnt=0, bit_cnt=0, bit_done=0, sample_valid=0, latched prescale=8.
REQ-028 On rst=0: synchroniser flops, s0, s1, rx_sync and sampled_bit SHALL reset to 1 (idle line).
REQ-029 Reset assertion mid-frame SHALL abort immediately; after release the block SHALL wait for a new enable rising edge.

Structure
REQ-030 Shared package uart_rx_pkg SHALL hold PRESCALE_W, BIT_CNT_W defaults and legal prescale constants (8, 16, 32).
REQ-031 Edge/bit counting SHALL be a sub-module edge_bit_counter; synchroniser and majority voter stay in uart_rx_sampler.

Verification
REQ-032 prescale=8, frame_bits=10, enable held 80 cycles -> edge_cnt wraps every 8 cycles, bit_cnt 0..9, single bit_done at cycle 80, bit_cnt back to 0.
REQ-033 prescale=16, rx_in low except a 1-cycle high glitch aligned to s1 capture tick -> sampled_bit=0, sample_valid pulse at edge_cnt=9.
REQ-034 prescale=32, rx_in high for ticks 14-16 at synchronised input -> sampled_bit=1 after tick 16.
REQ-035 prescale=12 at enable rise -> behaves as 8; prescale changed to 32 mid-frame -> period stays 8.
REQ-036 enable dropped at bit_cnt=4, edge_cnt=5 -> both counters 0 next cycle, no bit_done; data_sample_en dropped at edge_cnt=P/2-1 -> no sample_valid.
REQ-037 rst asserted mid-frame -> all outputs at reset values asynchronously, sampled_bit=1, rx_sync=1.
